// File: rtl/tanh_seq_pkg.sv
// ---------------------------------------------------------------------------
// tanh_seq_pkg
// Shared types and constants for the tanh vector sequencer.
//   seq_state_t      : sequencer FSM encoding (also visible on the debug port)
//   FP16_ONE_MAG     : FP16 magnitude bits of 1.0, used for saturation counting
//   TANH_LAT_DEFAULT : latency of the attached tanh pipeline
// ---------------------------------------------------------------------------
package tanh_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } seq_state_t;

    localparam logic [14:0] FP16_ONE_MAG     = 15'h3c00;
    localparam int          TANH_LAT_DEFAULT = 4;

endpackage

// File: rtl/seq_delay_line.sv
// ---------------------------------------------------------------------------
// seq_delay_line
// DEPTH-stage shift register, WIDTH bits per stage.
//   clk : clock
//   rst : asynchronous active-high reset, empties every stage
//   clr : synchronous clear, empties every stage (wins over shifting)
//   d   : value loaded into stage 0 each cycle
//   q   : output of the last stage (d delayed by DEPTH cycles)
// ---------------------------------------------------------------------------
module seq_delay_line #(
    parameter int DEPTH = 5,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stage [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
        end else if (clr) begin
            for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
        end else begin
            stage[0] <= d;
            for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
        end
    end

    assign q = stage[DEPTH-1];

endmodule

// File: rtl/tanh_vector_seq.sv
// ---------------------------------------------------------------------------
// tanh_vector_seq
// Streams a vector from an operand RAM through the FP16 tanh pipeline and
// writes the results into a result RAM, one element per cycle.
//   clk, rst          : clock, asynchronous active-high reset
//   start, abort, len : control; len is captured when start is accepted
//   in_rd, in_addr    : operand RAM read (data returns one cycle later)
//   in_data           : operand RAM read data
//   tanh_en, tanh_in  : drive the tanh unit (enable, operand)
//   tanh_out          : tanh unit result
//   out_we, out_addr,
//   out_data          : result RAM write port
//   busy, done        : status (busy in RUN/DRAIN, done is a 1-cycle pulse)
//   sat_count         : results of magnitude exactly 1.0 in the last vector
//   dbg_state         : current FSM state
//
// Control signalling: start and abort are single-cycle level strobes with no
// ready/acknowledge. start is accepted only when the FSM is in IDLE (it wins
// over abort there); abort is accepted only in RUN or DRAIN. A strobe seen in
// any other state is dropped, so the caller must not rely on it being held.
// ---------------------------------------------------------------------------
module tanh_vector_seq
    import tanh_seq_pkg::*;
#(
    parameter int ADDR_W   = 6,
    parameter int TANH_LAT = TANH_LAT_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W:0]   len,
    output logic              in_rd,
    output logic [ADDR_W-1:0] in_addr,
    input  logic [15:0]       in_data,
    output logic              tanh_en,
    output logic [15:0]       tanh_in,
    input  logic [15:0]       tanh_out,
    output logic              out_we,
    output logic [ADDR_W-1:0] out_addr,
    output logic [15:0]       out_data,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   sat_count,
    output seq_state_t        dbg_state
);

    // One stage covers the RAM read latency, TANH_LAT stages cover the tanh
    // pipeline, so the drain lasts the same TANH_LAT+1 cycles.
    localparam int                   DRAIN_W    = $clog2(TANH_LAT + 2);
    localparam logic [DRAIN_W-1:0]   DRAIN_LAST = DRAIN_W'(TANH_LAT);
    localparam logic [ADDR_W:0]      LEN_MAX    = {1'b1, {ADDR_W{1'b0}}};

    seq_state_t          state_q, state_d;
    logic [ADDR_W:0]     len_q;
    logic [ADDR_W-1:0]   rd_addr_q;
    logic [DRAIN_W-1:0]  drain_q;
    logic [ADDR_W:0]     sat_q;

    logic start_ok;
    logic abort_ok;
    logic last_rd;
    logic sat_hit;

    assign start_ok = (state_q == IDLE) && start;
    assign abort_ok = ((state_q == RUN) || (state_q == DRAIN)) && abort;
    assign last_rd  = (state_q == RUN) &&
                      ({1'b0, rd_addr_q} == (len_q - (ADDR_W+1)'(1)));

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) state_d = (len == '0) ? DONE : RUN;
            end
            RUN: begin
                if (abort)        state_d = IDLE;
                else if (last_rd) state_d = DRAIN;
            end
            DRAIN: begin
                if (abort)                        state_d = IDLE;
                else if (drain_q == DRAIN_LAST)   state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Read address, drain counter, saturation counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            len_q     <= '0;
            rd_addr_q <= '0;
            drain_q   <= '0;
            sat_q     <= '0;
        end else begin
            // Out-of-range lengths are clamped so RUN always terminates.
            if (start_ok) begin
                len_q     <= (len > LEN_MAX) ? LEN_MAX : len;
                rd_addr_q <= '0;
            end else if (state_q == RUN) begin
                rd_addr_q <= rd_addr_q + ADDR_W'(1);
            end

            if (state_q == DRAIN) drain_q <= drain_q + DRAIN_W'(1);
            else                  drain_q <= '0;

            // At most 2^ADDR_W hits per vector, so ADDR_W+1 bits never wrap.
            if (start_ok)     sat_q <= '0;
            else if (sat_hit) sat_q <= sat_q + (ADDR_W+1)'(1);
        end
    end

    // ------------------------------------------------------------------
    // {valid, addr} pipe aligned with the read latency + tanh latency.
    // Cleared on abort so nothing issued before the abort is written.
    // ------------------------------------------------------------------
    seq_delay_line #(
        .DEPTH (TANH_LAT + 1),
        .WIDTH (ADDR_W + 1)
    ) u_delay (
        .clk (clk),
        .rst (rst),
        .clr (abort_ok),
        .d   ({in_rd, in_addr}),
        .q   ({out_we, out_addr})
    );

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign in_rd     = (state_q == RUN);
    assign in_addr   = rd_addr_q;
    assign busy      = (state_q == RUN) || (state_q == DRAIN);
    // Enable stays high through DRAIN so every pipeline stage of the tanh
    // unit, including its ungated ROM register, advances in lock-step.
    assign tanh_en   = busy;
    assign tanh_in   = in_data;
    assign out_data  = tanh_out;
    assign done      = (state_q == DONE);
    assign sat_hit   = out_we && (out_data[14:0] == FP16_ONE_MAG);
    assign sat_count = sat_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_tanh_vector_seq.sv
// ---------------------------------------------------------------------------
// tb_tanh_vector_seq
// Table-driven bench for tanh_vector_seq with a behavioural operand RAM and a
// latency-4 tanh model. Cycle numbers are relative to the cycle in which
// start is high (cycle 0).
// ---------------------------------------------------------------------------
module tb_tanh_vector_seq;
    import tanh_seq_pkg::*;

    localparam int ADDR_W = 6;
    localparam int LAT    = 4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // ---------------- DUT signals ----------------
    logic              start = 1'b0;
    logic              abort = 1'b0;
    logic [ADDR_W:0]   len   = '0;
    logic              in_rd;
    logic [ADDR_W-1:0] in_addr;
    logic [15:0]       in_data;
    logic              tanh_en;
    logic [15:0]       tanh_in;
    logic [15:0]       tanh_out;
    logic              out_we;
    logic [ADDR_W-1:0] out_addr;
    logic [15:0]       out_data;
    logic              busy;
    logic              done;
    logic [ADDR_W:0]   sat_count;
    seq_state_t        dbg_state;

    tanh_vector_seq #(.ADDR_W(ADDR_W), .TANH_LAT(LAT)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .abort     (abort),
        .len       (len),
        .in_rd     (in_rd),
        .in_addr   (in_addr),
        .in_data   (in_data),
        .tanh_en   (tanh_en),
        .tanh_in   (tanh_in),
        .tanh_out  (tanh_out),
        .out_we    (out_we),
        .out_addr  (out_addr),
        .out_data  (out_data),
        .busy      (busy),
        .done      (done),
        .sat_count (sat_count),
        .dbg_state (dbg_state)
    );

    // ---------------- reference tanh (hand-computed FP16) ----------------
    function automatic logic [15:0] tanh_ref(input logic [15:0] x);
        case (x)
            16'h0000: tanh_ref = 16'h0000;  // tanh(0)  = 0
            16'h3c00: tanh_ref = 16'h3a18;  // tanh(1)  = 0.7616
            16'hbc00: tanh_ref = 16'hba18;  // tanh(-1) = -0.7616
            16'h4800: tanh_ref = 16'h3c00;  // tanh(8)  rounds to 1.0
            16'h4c00: tanh_ref = 16'h3c00;  // tanh(16) rounds to 1.0
            16'hc800: tanh_ref = 16'hbc00;  // tanh(-8) rounds to -1.0
            default:  tanh_ref = 16'h7e00;
        endcase
    endfunction

    // Operand RAM: one-cycle read latency.
    logic [15:0] mem [64];
    always @(posedge clk) begin
        if (in_rd) in_data <= mem[in_addr];
    end

    // Tanh model: enable-gated pipeline, result LAT cycles after sampling.
    logic [15:0] tpipe [LAT];
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < LAT; i++) tpipe[i] <= 16'h0000;
        end else if (tanh_en) begin
            tpipe[0] <= tanh_ref(tanh_in);
            for (int i = 1; i < LAT; i++) tpipe[i] <= tpipe[i-1];
        end
    end
    assign tanh_out = tpipe[LAT-1];

    // ---------------- scoreboard ----------------
    logic [15:0] exp_q[$];
    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] fill_val(input int fill, input int i);
        logic [15:0] pat [4];
        pat[0] = 16'h0000; pat[1] = 16'h3c00; pat[2] = 16'hbc00; pat[3] = 16'h4800;
        case (fill)
            0:       fill_val = pat[i % 4];
            1:       fill_val = 16'h4c00;
            2:       fill_val = 16'h3c00;
            default: fill_val = 16'hc800;
        endcase
    endfunction

    // Per-run observations.
    int wr_n, rd_n, busy_n, done_cyc, addr_err, sat_at_done;
    int busy_first, busy_last;
    logic busy_c4;
    seq_state_t state_c4;

    // ---------------- driver / monitor ----------------
    // abort_at / pulse_at / stop_at / rst_at: cycle numbers, 0 = unused.
    task automatic run_vec(input int l, input int fill, input int abort_at,
                           input int pulse_at, input int stop_at, input int rst_at);
        logic [31:0] zero_vec;
        exp_q.delete();
        wr_n = 0; rd_n = 0; busy_n = 0; done_cyc = -1; addr_err = 0;
        sat_at_done = -1; busy_first = -1; busy_last = -1;
        busy_c4 = 1'bx; state_c4 = DONE;
        for (int i = 0; i < l; i++) begin
            mem[i] = fill_val(fill, i);
            exp_q.push_back(tanh_ref(mem[i]));
        end
        @(negedge clk);
        start = 1'b1;
        len   = (ADDR_W+1)'(l);
        @(posedge clk);
        #1 start = 1'b0;
        for (int c = 1; c <= 300; c++) begin
            @(negedge clk);
            if (c == 4) begin busy_c4 = busy; state_c4 = dbg_state; end
            if (in_rd) begin
                rd_n++;
                if (int'(in_addr) != c - 1) addr_err++;
            end
            if (busy) begin
                busy_n++;
                if (busy_first < 0) busy_first = c;
                busy_last = c;
            end
            if (out_we) begin
                wr_n++;
                check("wr_addr", 32'(out_addr), 32'(wr_n - 1));
                check("wr_cycle", 32'(c), 32'(int'(out_addr) + 2 + LAT));
                if (exp_q.size() > 0) check("wr_data", 32'(out_data), 32'(exp_q.pop_front()));
                else                  check("wr_extra", 32'(wr_n), 32'(l));
            end
            if (done) begin
                done_cyc    = c;
                sat_at_done = int'(sat_count);
                break;
            end
            if (c == stop_at) break;
            if (c == rst_at) begin
                rst = 1'b1;
                #1;
                zero_vec = {6'd0, in_rd, in_addr, tanh_en, out_we, out_addr,
                            busy, done, sat_count, dbg_state};
                check("async_reset_outputs", zero_vec, 32'd0);
                @(negedge clk);
                rst = 1'b0;
                break;
            end
            abort = (c == abort_at);
            start = (c == pulse_at);
        end
        abort = 1'b0;
        start = 1'b0;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        int l;
        int fill;
        int pulse_at;
        int exp_done;
        int exp_sat;
    } vec_t;

    vec_t vecs [7];

    // ---------------- test sequence ----------------
    initial begin
        int idle_we;

        vecs[0] = '{l: 4,  fill: 0, pulse_at: 0, exp_done: 10, exp_sat: 1};
        vecs[1] = '{l: 0,  fill: 0, pulse_at: 0, exp_done: 1,  exp_sat: 0};
        vecs[2] = '{l: 64, fill: 1, pulse_at: 0, exp_done: 70, exp_sat: 64};
        vecs[3] = '{l: 1,  fill: 2, pulse_at: 0, exp_done: 7,  exp_sat: 0};
        vecs[4] = '{l: 7,  fill: 3, pulse_at: 0, exp_done: 13, exp_sat: 7};
        vecs[5] = '{l: 5,  fill: 0, pulse_at: 2, exp_done: 11, exp_sat: 1};
        vecs[6] = '{l: 3,  fill: 2, pulse_at: 0, exp_done: 9,  exp_sat: 0};

        for (int i = 0; i < 64; i++) mem[i] = 16'h0000;

        // Reset state while rst is held.
        repeat (3) @(negedge clk);
        check("reset_busy",      32'(busy),      32'd0);
        check("reset_in_rd",     32'(in_rd),     32'd0);
        check("reset_out_we",    32'(out_we),    32'd0);
        check("reset_done",      32'(done),      32'd0);
        check("reset_sat_count", 32'(sat_count), 32'd0);
        check("reset_state",     32'(dbg_state), 32'(IDLE));
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Back-to-back table runs (each start lands in the cycle after done).
        for (int v = 0; v < 7; v++) begin
            run_vec(vecs[v].l, vecs[v].fill, 0, vecs[v].pulse_at, 0, 0);
            check($sformatf("v%0d_done_cycle", v), 32'(done_cyc),    32'(vecs[v].exp_done));
            check($sformatf("v%0d_writes", v),     32'(wr_n),        32'(vecs[v].l));
            check($sformatf("v%0d_reads", v),      32'(rd_n),        32'(vecs[v].l));
            check($sformatf("v%0d_rd_addr", v),    32'(addr_err),    32'd0);
            check($sformatf("v%0d_busy_cycles", v), 32'(busy_n),
                  32'(vecs[v].l == 0 ? 0 : vecs[v].l + 5));
            check($sformatf("v%0d_busy_first", v), 32'(busy_first),
                  32'(vecs[v].l == 0 ? -1 : 1));
            check($sformatf("v%0d_busy_last", v),  32'(busy_last),
                  32'(vecs[v].l == 0 ? -1 : vecs[v].l + 5));
            check($sformatf("v%0d_sat_count", v),  32'(sat_at_done), 32'(vecs[v].exp_sat));
        end

        // Abort in cycle 3 of a len=10 run, then start in cycle 5.
        run_vec(10, 1, 3, 0, 4, 0);
        check("abort_busy_c4",  32'(busy_c4),  32'd0);
        check("abort_state_c4", 32'(state_c4), 32'(IDLE));
        check("abort_writes",   32'(wr_n),     32'd0);
        check("abort_no_done",  32'(done_cyc), 32'(-1));
        check("abort_sat_hold", 32'(sat_count), 32'd0);
        run_vec(2, 0, 0, 0, 0, 0);
        check("post_abort_done",   32'(done_cyc),    32'd8);
        check("post_abort_writes", 32'(wr_n),        32'd2);
        check("post_abort_sat",    32'(sat_at_done), 32'd0);

        // Reset in DRAIN (cycle 7 of len=3) after one saturated write.
        run_vec(3, 1, 0, 0, 0, 7);
        check("rst_writes_before", 32'(wr_n),     32'd2);
        check("rst_no_done",       32'(done_cyc), 32'(-1));
        idle_we = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (out_we || busy || done) idle_we++;
        end
        check("rst_quiet_after", 32'(idle_we),   32'd0);
        check("rst_sat_cleared", 32'(sat_count), 32'd0);
        run_vec(2, 0, 0, 0, 0, 0);
        check("post_rst_done",   32'(done_cyc), 32'd8);
        check("post_rst_writes", 32'(wr_n),     32'd2);
        check("post_rst_reads",  32'(rd_n),     32'd2);
        check("post_rst_busy",   32'(busy_n),   32'd7);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
